// File: rtl/ad9361_init_sequencer_if.sv
// SPI word handshake between the init sequencer and the SPI_configure master.
// master: sequencer side (issues 24-bit words, consumes RX pulses).
// slave:  SPI master side.
interface ad9361_init_sequencer_if;
  logic [23:0] tx_word;
  logic        tx_dv;
  logic        tx_ready;
  logic        rx_dv;
  logic [7:0]  rx_byte;

  modport master (
    output tx_word, tx_dv,
    input  tx_ready, rx_dv, rx_byte
  );

  modport slave (
    input  tx_word, tx_dv,
    output tx_ready, rx_dv, rx_byte
  );
endinterface

// File: rtl/ad9361_init_sequencer.sv
// Table-driven AD9361 register-initialisation sequencer.
// Walks an external command table (WRITE / VERIFY / WAIT / END), issues
// 24-bit SPI words over the interface handshake, verifies masked readbacks
// with retry and reports done/error with the failing table index.
// Optional feature macro: AD9361_SEQ_TIMEOUT_EN (per-transfer watchdog).
module ad9361_init_sequencer #(
  parameter int unsigned TBL_AW      = 6,
  parameter int unsigned WAIT_SHIFT  = 4,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_Start,
  output logic [TBL_AW-1:0]     o_Tbl_Addr,
  input  logic [31:0]           i_Tbl_Data,
  ad9361_init_sequencer_if.master spi,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Err,
  output logic [TBL_AW-1:0]     o_Err_Idx,
  output logic [7:0]            o_Last_Rd
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned DW = 20 + WAIT_SHIFT;
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_WAIT_RDY, ST_SEND,
    ST_WAIT_RX, ST_DELAY, ST_DONE, ST_ERROR
  } state_t;

  typedef enum logic [1:0] {OP_WRITE, OP_VERIFY, OP_WAIT, OP_END} op_t;

  state_t          state_q, state_d;
  logic [31:0]     entry_q;
  logic [RW-1:0]   retry_q;
  logic [DW-1:0]   dly_q, dly_load;
  logic            start_go, advance, retry_inc, last_entry, verify_ok, to_hit;
  op_t             op_q, op_in;
  logic            unused_bits;

  assign op_q        = op_t'(entry_q[31:30]);
  assign op_in       = op_t'(i_Tbl_Data[31:30]);
  assign dly_load    = DW'(i_Tbl_Data[27:8]) << WAIT_SHIFT;
  assign last_entry  = (o_Tbl_Addr == '1);
  assign verify_ok   = ((spi.rx_byte ^ entry_q[15:8]) & entry_q[7:0]) == '0;
  assign spi.tx_dv   = (state_q == ST_SEND);
  assign unused_bits = ^{entry_q[29:28], i_Tbl_Data[29:28]};

`ifdef AD9361_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] to_q;
  logic          waiting;

  assign waiting = (state_q == ST_WAIT_RDY) || (state_q == ST_WAIT_RX);
  assign to_hit  = waiting && (to_q == TO_LAST);

  // Watchdog: restarts on every state change, counts only while waiting.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)                 to_q <= '0;
    else if (state_d != state_q)  to_q <= '0;
    else if (waiting)             to_q <= to_q + 1'b1;
  end
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYC;
  assign to_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d   = state_q;
    start_go  = 1'b0;
    advance   = 1'b0;
    retry_inc = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_Start) begin
          start_go = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        case (op_in)
          OP_WRITE, OP_VERIFY: state_d = ST_WAIT_RDY;
          OP_WAIT: begin
            if (dly_load == '0) advance = 1'b1;
            else                state_d = ST_DELAY;
          end
          default: state_d = ST_DONE;
        endcase
      end
      ST_WAIT_RDY: if (spi.tx_ready) state_d = ST_SEND;
      ST_SEND:     state_d = ST_WAIT_RX;
      ST_WAIT_RX: begin
        if (spi.rx_dv) begin
          if (op_q == OP_VERIFY && !verify_ok) begin
            if (retry_q < RETRY_LIM) begin
              retry_inc = 1'b1;
              state_d   = ST_WAIT_RDY;
            end else begin
              state_d = ST_ERROR;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_DELAY: if (dly_q == DW'(1)) advance = 1'b1;
      default:  state_d = ST_IDLE;
    endcase
    // The last table slot finishes the run rather than wrapping to entry 0.
    if (advance) state_d = last_entry ? ST_DONE : ST_FETCH;
    if (to_hit && state_d == state_q) state_d = ST_ERROR;
  end

  // Datapath: table index, entry latch, delay/retry counters, status.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Tbl_Addr  <= '0;
      entry_q     <= '0;
      retry_q     <= '0;
      dly_q       <= '0;
      spi.tx_word <= '0;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
      o_Err       <= 1'b0;
      o_Err_Idx   <= '0;
      o_Last_Rd   <= '0;
    end else begin
      if (start_go) begin
        o_Tbl_Addr <= '0;
        retry_q    <= '0;
        o_Busy     <= 1'b1;
        o_Done     <= 1'b0;
        o_Err      <= 1'b0;
        o_Err_Idx  <= '0;
      end
      if (state_q == ST_DECODE) begin
        entry_q <= i_Tbl_Data;
        dly_q   <= dly_load;
      end
      if (state_q == ST_DELAY) dly_q <= dly_q - 1'b1;
      if (state_q == ST_WAIT_RDY && state_d == ST_SEND) begin
        if (op_q == OP_WRITE) spi.tx_word <= {1'b1, 3'b000, entry_q[27:16], entry_q[15:8]};
        else                  spi.tx_word <= {1'b0, 3'b000, entry_q[27:16], 8'h00};
      end
      if (state_q == ST_WAIT_RX && spi.rx_dv && op_q == OP_VERIFY)
        o_Last_Rd <= spi.rx_byte;
      if (retry_inc) retry_q <= retry_q + 1'b1;
      if (advance) begin
        retry_q <= '0;
        if (!last_entry) o_Tbl_Addr <= o_Tbl_Addr + 1'b1;
      end
      if (state_d == ST_DONE && state_q != ST_DONE) begin
        o_Done <= 1'b1;
        o_Busy <= 1'b0;
      end
      if (state_d == ST_ERROR && state_q != ST_ERROR) begin
        o_Err     <= 1'b1;
        o_Err_Idx <= o_Tbl_Addr;
        o_Busy    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ad9361_init_sequencer.sv
// Directed bench for ad9361_init_sequencer: table memory model with 1-cycle
// read latency and an SPI master model that answers each TX_DV with one
// RX_DV pulse after a programmable latency.
`timescale 1ns/1ps
module tb_ad9361_init_sequencer;
  localparam int unsigned AW = 2;

  logic          test_clk = 1'b0;
  logic          i_Rst_n  = 1'b0;
  logic          start    = 1'b0;
  logic [AW-1:0] tbl_addr;
  logic [31:0]   tbl_data = '0;
  logic          busy, done, err;
  logic [AW-1:0] err_idx;
  logic [7:0]    last_rd;

  ad9361_init_sequencer_if spi();

  ad9361_init_sequencer #(
    .TBL_AW(AW), .WAIT_SHIFT(4), .MAX_RETRY(3), .TIMEOUT_CYC(64)
  ) dut (
    .i_Clk(test_clk), .i_Rst_L(i_Rst_n), .i_Start(start),
    .o_Tbl_Addr(tbl_addr), .i_Tbl_Data(tbl_data), .spi(spi),
    .o_Busy(busy), .o_Done(done), .o_Err(err),
    .o_Err_Idx(err_idx), .o_Last_Rd(last_rd)
  );

  always #5 test_clk = ~test_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] tbl [4];
  bit          model_en   = 1'b1;
  int          model_lat  = 1;
  logic [7:0]  model_byte = 8'h00;
  bit          rx_pending = 1'b0;
  int          rx_due     = 0;
  int          dv_q[$];
  int          rx_q[$];
  logic [23:0] word_q[$];

  always @(posedge test_clk) cyc <= cyc + 1;

  // Synchronous table memory, one cycle read latency.
  always @(posedge test_clk) tbl_data <= tbl[tbl_addr];

  // SPI master model: log every TX_DV, answer with one RX_DV after model_lat.
  initial begin
    spi.rx_dv    = 1'b0;
    spi.rx_byte  = 8'h00;
    spi.tx_ready = 1'b1;
    forever begin
      @(negedge test_clk);
      spi.rx_dv = 1'b0;
      if (!i_Rst_n) begin
        rx_pending = 1'b0;
      end else begin
        if (rx_pending && cyc == rx_due) begin
          spi.rx_dv   = 1'b1;
          spi.rx_byte = model_byte;
          rx_pending  = 1'b0;
          rx_q.push_back(cyc);
        end
        if (spi.tx_dv) begin
          dv_q.push_back(cyc);
          word_q.push_back(spi.tx_word);
          if (model_en) begin
            rx_pending = 1'b1;
            rx_due     = cyc + model_lat;
          end
        end
      end
    end
  end

  task automatic load4(input logic [31:0] a, b, c, d);
    tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
  endtask

  task automatic clear_log();
    dv_q.delete(); rx_q.delete(); word_q.delete();
    rx_pending = 1'b0;
  endtask

  task automatic pulse_start(output int sc);
    @(negedge test_clk);
    start = 1'b1;
    sc    = cyc;
    @(negedge test_clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int end_cyc, output bit timed_out);
    timed_out = 1'b1;
    end_cyc   = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge test_clk);
      if (done || err) begin
        end_cyc   = cyc;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge test_clk);
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("FAIL reset_status got %b want 000", {busy, done, err});
    end
    checks++;
    if (spi.tx_dv !== 1'b0 || spi.tx_word !== 24'h0) begin
      errors++; $display("FAIL reset_tx got dv=%b word=%h want 0/000000", spi.tx_dv, spi.tx_word);
    end
    checks++;
    if (tbl_addr !== '0 || err_idx !== '0 || last_rd !== 8'h00) begin
      errors++; $display("FAIL reset_regs got addr=%0d idx=%0d rd=%h want 0/0/00", tbl_addr, err_idx, last_rd);
    end
    i_Rst_n = 1'b1;
  endtask

  task automatic test_write();
    int sc, ec, r; bit to;
    load4(32'h0002_5A00, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000);
    model_en = 1'b1; model_lat = 30;
    @(negedge test_clk); spi.tx_ready = 1'b0;
    clear_log();
    pulse_start(sc);
    repeat (10) @(negedge test_clk);
    checks++;
    if (dv_q.size() != 0 || busy !== 1'b1) begin
      errors++; $display("FAIL write_hold_rdy got dvs=%0d busy=%b want 0/1", dv_q.size(), busy);
    end
    spi.tx_ready = 1'b1;
    r = cyc;
    wait_end(200, ec, to);
    checks++;
    if (to) begin errors++; $display("FAIL write_timeout got no done want done"); end
    checks++;
    if (dv_q.size() != 1 || dv_q[0] != r + 1) begin
      errors++; $display("FAIL write_dv got n=%0d at=%0d want 1 at %0d", dv_q.size(), dv_q[0], r + 1);
    end
    checks++;
    if (word_q[0] !== 24'h80025A) begin
      errors++; $display("FAIL write_word got %h want 80025a", word_q[0]);
    end
    checks++;
    if ({done, busy, err} !== 3'b100 || ec - rx_q[0] != 3) begin
      errors++; $display("FAIL write_done got dbe=%b lat=%0d want 100/3", {done, busy, err}, ec - rx_q[0]);
    end
  endtask

  task automatic test_verify_pass();
    int sc, ec; bit to;
    load4(32'h4037_0A0F, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000);
    model_byte = 8'hFA; model_lat = 5;
    clear_log();
    pulse_start(sc);
    wait_end(200, ec, to);
    checks++;
    if (to || dv_q.size() != 1 || dv_q[0] - sc != 4) begin
      errors++; $display("FAIL verify_latency got to=%b n=%0d lat=%0d want 0/1/4", to, dv_q.size(), dv_q[0] - sc);
    end
    checks++;
    if (word_q[0] !== 24'h003700) begin
      errors++; $display("FAIL verify_word got %h want 003700", word_q[0]);
    end
    checks++;
    if (last_rd !== 8'hFA || done !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL verify_result got rd=%h done=%b err=%b want fa/1/0", last_rd, done, err);
    end
  endtask

  task automatic test_verify_retry();
    int sc, ec; bit to;
    load4(32'h0010_4400, 32'h4037_0A0F, 32'hC000_0000, 32'hC000_0000);
    model_byte = 8'h05; model_lat = 3;
    clear_log();
    pulse_start(sc);
    wait_end(300, ec, to);
    checks++;
    if (to || dv_q.size() != 5) begin
      errors++; $display("FAIL retry_dv_count got to=%b n=%0d want 0/5", to, dv_q.size());
    end
    checks++;
    if (word_q[4] !== 24'h003700) begin
      errors++; $display("FAIL retry_word got %h want 003700", word_q[4]);
    end
    checks++;
    if ({err, done, busy} !== 3'b100 || err_idx !== 2'd1) begin
      errors++; $display("FAIL retry_err got edb=%b idx=%0d want 100/1", {err, done, busy}, err_idx);
    end
    checks++;
    if (last_rd !== 8'h05 || ec - rx_q[4] != 1) begin
      errors++; $display("FAIL retry_timing got rd=%h lat=%0d want 05/1", last_rd, ec - rx_q[4]);
    end
  endtask

  task automatic test_wait();
    int sc, ec; bit to;
    load4(32'h0001_1100, 32'h8000_0500, 32'h0002_2200, 32'hC000_0000);
    model_lat = 2;
    clear_log();
    pulse_start(sc);
    wait_end(400, ec, to);
    checks++;
    if (to || dv_q.size() != 2 || done !== 1'b1) begin
      errors++; $display("FAIL wait_run got to=%b n=%0d done=%b want 0/2/1", to, dv_q.size(), done);
    end
    // 80 DELAY cycles + FETCH/DECODE of the WAIT entry + 4 to the next DV.
    checks++;
    if (dv_q[1] - rx_q[0] != 86) begin
      errors++; $display("FAIL wait_gap got %0d want 86", dv_q[1] - rx_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    int sc, sc2, ec; bit to;
    load4(32'h0100_A000, 32'h0101_A100, 32'h0102_A200, 32'h0103_A300);
    model_lat = 1;
    clear_log();
    pulse_start(sc);
    repeat (6) @(negedge test_clk);
    pulse_start(sc2);
    wait_end(200, ec, to);
    repeat (20) @(negedge test_clk);
    checks++;
    if (to || dv_q.size() != 4) begin
      errors++; $display("FAIL noend_dv_count got to=%b n=%0d want 0/4", to, dv_q.size());
    end
    checks++;
    if (word_q[0] !== 24'h8100A0 || word_q[3] !== 24'h8103A3) begin
      errors++; $display("FAIL noend_words got %h %h want 8100a0 8103a3", word_q[0], word_q[3]);
    end
    checks++;
    if (dv_q[1] - rx_q[0] != 4) begin
      errors++; $display("FAIL b2b_gap got %0d want 4", dv_q[1] - rx_q[0]);
    end
    checks++;
    if ({done, err, busy} !== 3'b100 || tbl_addr !== 2'd3) begin
      errors++; $display("FAIL noend_done got deb=%b addr=%0d want 100/3", {done, err, busy}, tbl_addr);
    end
  endtask

  task automatic test_no_rx();
    int sc, ec; bit to;
    load4(32'h0002_5A00, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000);
    model_en = 1'b0;
    clear_log();
    pulse_start(sc);
`ifdef AD9361_SEQ_TIMEOUT_EN
    wait_end(200, ec, to);
    checks++;
    if (to || err !== 1'b1 || err_idx !== 2'd0 || ec - dv_q[0] != 65) begin
      errors++; $display("FAIL timeout got to=%b err=%b idx=%0d lat=%0d want 0/1/0/65", to, err, err_idx, ec - dv_q[0]);
    end
`else
    repeat (200) @(negedge test_clk);
    checks++;
    if ({busy, err, done} !== 3'b100 || dv_q.size() != 1) begin
      errors++; $display("FAIL hang_wait got bed=%b n=%0d want 100/1", {busy, err, done}, dv_q.size());
    end
    ec = 0; to = 1'b0;
`endif
    #2 i_Rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err} !== 3'b000 || tbl_addr !== '0) begin
      errors++; $display("FAIL rst_wait_rx got bde=%b addr=%0d want 000/0", {busy, done, err}, tbl_addr);
    end
    @(negedge test_clk);
    i_Rst_n  = 1'b1;
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid_send();
    int sc, ec; bit to; bit seen;
    load4(32'h0002_5A00, 32'h0003_3300, 32'hC000_0000, 32'hC000_0000);
    model_lat = 10;
    clear_log();
    pulse_start(sc);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge test_clk);
      seen = spi.tx_dv;
    end
    #2 i_Rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || spi.tx_dv !== 1'b0 || spi.tx_word !== 24'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_send got seen=%b dv=%b word=%h busy=%b want 1/0/000000/0", seen, spi.tx_dv, spi.tx_word, busy);
    end
    @(negedge test_clk);
    i_Rst_n = 1'b1;
    clear_log();
    pulse_start(sc);
    wait_end(200, ec, to);
    checks++;
    if (to || dv_q.size() != 2 || word_q[0] !== 24'h80025A || word_q[1] !== 24'h800333 || done !== 1'b1) begin
      errors++; $display("FAIL rst_replay got to=%b n=%0d w0=%h w1=%h done=%b want 0/2/80025a/800333/1", to, dv_q.size(), word_q[0], word_q[1], done);
    end
  endtask

  initial begin
    load4(32'hC000_0000, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000);
    test_reset();
    test_write();
    test_verify_pass();
    test_verify_retry();
    test_wait();
    test_back_to_back();
    test_no_rx();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
